inst_fetch: RTL and testbench

//   Instruction fetch stage of the 31-instruction MIPS core: owns the PC and requests words from

---
 rtl/inst_fetch_pkg.sv | 22 ++
 rtl/inst_fetch_if.sv | 14 +
 rtl/inst_fetch_pc_reg.sv | 39 +++
 rtl/inst_fetch.sv | 129 ++++++++++++
 tb/tb_inst_fetch.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/inst_fetch_pkg.sv
`default_nettype none
// ============================================================================
// inst_fetch_pkg : shared state encodings, reset PC and field helpers | rev 1.0
// ============================================================================
package inst_fetch_pkg;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_HOLD  = 2'd1,
    ST_DRAIN = 2'd2
  } fetch_state_e;

  localparam logic [31:0] C_RESET_PC  = 32'h0040_0000;
  localparam int          C_IMM16_MSB = 15;
  localparam int          C_IMM16_LSB = 0;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage
`default_nettype wire

// File: rtl/inst_fetch_if.sv
`default_nettype none
// ============================================================================
// inst_fetch_if : instruction memory req/ack bus | rev 1.0
// ============================================================================
interface inst_fetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (output imem_req, imem_addr, input imem_ack, imem_rdata);
  modport slave  (input imem_req, imem_addr, output imem_ack, imem_rdata);
endinterface
`default_nettype wire

// File: rtl/inst_fetch_pc_reg.sv
`default_nettype none
// ============================================================================
// inst_fetch_pc_reg : program counter with load (priority) and +4 step | rev 1.0
// ============================================================================
module inst_fetch_pc_reg #(
  parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
  input  wire logic        clk,
  input  wire logic        rst,
  input  wire logic        load,
  input  wire logic [31:0] load_pc,
  input  wire logic        inc,
  output logic [31:0]      pc
);

  logic [31:0] pc_d;
  logic [31:0] pc_q;

  always_comb begin
    pc_d = pc_q;
    if (load) begin
      pc_d = load_pc;
    end else if (inc) begin
      pc_d = pc_q + 32'd4;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc = pc_q;

endmodule
`default_nettype wire

// File: rtl/inst_fetch.sv
`default_nettype none
// ============================================================================
// inst_fetch : PC ownership, imem req/ack fetch, instruction hold and redirect | rev 1.0
// ============================================================================
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = C_RESET_PC
) (
  input  wire logic        clk,
  input  wire logic        rst,
  inst_fetch_if.master     imem,
  input  wire logic        redirect_valid,
  input  wire logic [31:0] redirect_pc,
  input  wire logic        stall,
  output logic             inst_valid,
  output logic [31:0]      inst,
  output logic [31:0]      inst_pc,
  output logic [31:0]      pc_plus4,
  output logic [15:0]      imm16
);

  fetch_state_e state_d, state_q;
  logic [31:0]  req_addr_d, req_addr_q;
  logic [31:0]  inst_d, inst_q;
  logic [31:0]  inst_pc_d, inst_pc_q;
  logic [31:0]  pc_plus4_d, pc_plus4_q;

  logic [31:0]  pc;
  logic [31:0]  new_pc;
  logic         pc_load;
  logic         pc_inc;

  assign new_pc = word_align(redirect_pc);

  inst_fetch_pc_reg #(
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk     (clk),
    .rst     (rst),
    .load    (pc_load),
    .load_pc (new_pc),
    .inc     (pc_inc),
    .pc      (pc)
  );

  always_comb begin
    state_d    = state_q;
    req_addr_d = req_addr_q;
    inst_d     = inst_q;
    inst_pc_d  = inst_pc_q;
    pc_plus4_d = pc_plus4_q;
    pc_load    = 1'b0;
    pc_inc     = 1'b0;

    case (state_q)
      ST_FETCH: begin
        if (redirect_valid) begin
          pc_load = 1'b1;
          if (imem.imem_ack) begin
            req_addr_d = new_pc;
          end else begin
            // Request must stay stable until its ack, so retire it in DRAIN.
            state_d = ST_DRAIN;
          end
        end else if (imem.imem_ack) begin
          inst_d     = imem.imem_rdata;
          inst_pc_d  = req_addr_q;
          pc_plus4_d = req_addr_q + 32'd4;
          pc_inc     = 1'b1;
          state_d    = ST_HOLD;
        end
      end

      ST_HOLD: begin
        if (redirect_valid) begin
          pc_load    = 1'b1;
          req_addr_d = new_pc;
          state_d    = ST_FETCH;
        end else if (!stall) begin
          req_addr_d = pc;
          state_d    = ST_FETCH;
        end
      end

      ST_DRAIN: begin
        if (redirect_valid) begin
          pc_load = 1'b1;
        end
        if (imem.imem_ack) begin
          // A redirect landing on the draining ack wins over the older target.
          req_addr_d = redirect_valid ? new_pc : pc;
          state_d    = ST_FETCH;
        end
      end

      default: begin
        state_d = ST_FETCH;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_FETCH;
      req_addr_q <= RESET_PC;
      inst_q     <= '0;
      inst_pc_q  <= '0;
      pc_plus4_q <= '0;
    end else begin
      state_q    <= state_d;
      req_addr_q <= req_addr_d;
      inst_q     <= inst_d;
      inst_pc_q  <= inst_pc_d;
      pc_plus4_q <= pc_plus4_d;
    end
  end

  assign imem.imem_req  = (state_q != ST_HOLD) && !rst;
  assign imem.imem_addr = req_addr_q;

  assign inst_valid = (state_q == ST_HOLD);
  assign inst       = inst_q;
  assign inst_pc    = inst_pc_q;
  assign pc_plus4   = pc_plus4_q;
  assign imm16      = inst_q[C_IMM16_MSB:C_IMM16_LSB];

endmodule
`default_nettype wire

// File: tb/tb_inst_fetch.sv
`default_nettype none
// ============================================================================
// tb_inst_fetch : self-checking bench for inst_fetch | rev 1.0
// ============================================================================
module tb_inst_fetch;

  typedef struct {
    int          lat;
    logic [31:0] addr;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        stall;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic [31:0] pc_plus4;
  logic [15:0] imm16;

  int          tests = 0;
  int          fails = 0;
  int          lat   = 1;
  int          wait_cnt = 0;
  logic        prev_valid = 1'b0;
  logic [31:0] exp_q[$];

  inst_fetch_if imem_bus ();

  inst_fetch dut (
    .clk            (clk),
    .rst            (rst),
    .imem           (imem_bus),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .stall          (stall),
    .inst_valid     (inst_valid),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .pc_plus4       (pc_plus4),
    .imm16          (imm16)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h2048_0005;
  endfunction

  // Memory model: ack after lat request cycles (lat=1 is zero-wait)
  assign imem_bus.imem_ack   = imem_bus.imem_req && (wait_cnt == lat - 1);
  assign imem_bus.imem_rdata = mem_word(imem_bus.imem_addr);

  always @(posedge clk) begin
    wait_cnt <= (imem_bus.imem_req && !imem_bus.imem_ack) ? wait_cnt + 1 : 0;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard: each newly presented instruction pops the oldest expected address
  always @(negedge clk) begin
    logic [31:0] e;
    logic [31:0] w;
    if (inst_valid === 1'b1 && !prev_valid) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL sb_unexpected: got inst_pc %h expected none", inst_pc);
      end else begin
        e = exp_q.pop_front();
        w = mem_word(e);
        chk("sb_inst_pc", inst_pc, e);
        chk("sb_inst", inst, w);
        chk("sb_pc_plus4", pc_plus4, e + 32'd4);
        chk("sb_imm16", {16'h0, imm16}, {16'h0, w[15:0]});
      end
    end
    prev_valid <= (inst_valid === 1'b1);
  end

  // Called at a negedge in the first request cycle of a fetch.
  task automatic fetch_wait(input int l, input logic [31:0] addr);
    int   cycles;
    logic stable;
    logic got;
    cycles = 0;
    stable = 1'b1;
    got    = 1'b0;
    while (!got && cycles < 20) begin
      cycles++;
      if (imem_bus.imem_addr !== addr || imem_bus.imem_req !== 1'b1) stable = 1'b0;
      if (imem_bus.imem_ack === 1'b1) got = 1'b1;
      else @(negedge clk);
    end
    chk("ack_latency", cycles, l);
    chk("addr_stable", {31'h0, stable}, 32'h1);
    @(negedge clk);
    chk("valid_after_ack", {31'h0, inst_valid}, 32'h1);
  endtask

  task automatic consume_and_fetch(input int l, input logic [31:0] addr);
    lat = l;
    exp_q.push_back(addr);
    stall = 1'b0;
    @(negedge clk);
    stall = 1'b1;
    chk("fetch_start_req", {31'h0, imem_bus.imem_req}, 32'h1);
    fetch_wait(l, addr);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req"}, {31'h0, imem_bus.imem_req}, 32'h0);
    chk({tag, "_valid"}, {31'h0, inst_valid}, 32'h0);
    chk({tag, "_inst"}, inst, 32'h0);
    chk({tag, "_inst_pc"}, inst_pc, 32'h0);
    chk({tag, "_pc_plus4"}, pc_plus4, 32'h0);
    chk({tag, "_imm16"}, {16'h0, imm16}, 32'h0);
    chk({tag, "_addr"}, imem_bus.imem_addr, 32'h0040_0000);
  endtask

  vec_t vecs[4];
  logic stall_ok;

  initial begin
    vecs[0] = '{lat: 1, addr: 32'h0040_0004};
    vecs[1] = '{lat: 3, addr: 32'h0040_0008};
    vecs[2] = '{lat: 2, addr: 32'h0040_000C};
    vecs[3] = '{lat: 5, addr: 32'h0040_0010};

    rst = 1'b1; stall = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; lat = 1;
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");

    // Zero-wait first fetch right after reset release
    exp_q.push_back(32'h0040_0000);
    rst = 1'b0;
    #1;
    chk("first_req", {31'h0, imem_bus.imem_req}, 32'h1);
    chk("first_ack_zero_wait", {31'h0, imem_bus.imem_ack}, 32'h1);
    @(negedge clk);
    chk("first_valid", {31'h0, inst_valid}, 32'h1);
    chk("first_inst", inst, 32'h2008_0005);

    // Stall held in HOLD
    stall_ok = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (imem_bus.imem_req !== 1'b0 || inst_pc !== 32'h0040_0000 ||
          inst !== 32'h2008_0005 || inst_valid !== 1'b1) stall_ok = 1'b0;
    end
    chk("stall_hold", {31'h0, stall_ok}, 32'h1);

    for (int i = 0; i < 4; i++) begin
      consume_and_fetch(vecs[i].lat, vecs[i].addr);
    end

    // Redirect while a 3-cycle fetch is outstanding
    lat = 3;
    stall = 1'b0;
    @(negedge clk);
    stall = 1'b1;
    @(negedge clk);
    redirect_valid = 1'b1; redirect_pc = 32'h0040_0100;
    @(negedge clk);
    redirect_valid = 1'b0;
    chk("drain_ack", {31'h0, imem_bus.imem_ack}, 32'h1);
    chk("drain_old_addr", imem_bus.imem_addr, 32'h0040_0014);
    chk("drain_valid", {31'h0, inst_valid}, 32'h0);
    @(negedge clk);
    chk("redir_addr", imem_bus.imem_addr, 32'h0040_0100);
    chk("redir_discard", {31'h0, inst_valid}, 32'h0);
    exp_q.push_back(32'h0040_0100);
    fetch_wait(3, 32'h0040_0100);

    // Redirect in HOLD under stall, unaligned target
    lat = 2;
    redirect_valid = 1'b1; redirect_pc = 32'h0040_0103;
    @(negedge clk);
    redirect_valid = 1'b0;
    chk("hold_redir_valid", {31'h0, inst_valid}, 32'h0);
    chk("hold_redir_addr", imem_bus.imem_addr, 32'h0040_0100);
    exp_q.push_back(32'h0040_0100);
    fetch_wait(2, 32'h0040_0100);

    // Wrap at top of address space
    lat = 1;
    exp_q.push_back(32'hFFFF_FFFC);
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    @(negedge clk);
    redirect_valid = 1'b0;
    fetch_wait(1, 32'hFFFF_FFFC);
    consume_and_fetch(2, 32'h0000_0000);

    // Reset in the middle of a fetch
    lat = 4;
    stall = 1'b0;
    @(negedge clk);
    stall = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk_reset_outputs("midrst");
    lat = 1;
    exp_q.push_back(32'h0040_0000);
    rst = 1'b0;
    #1;
    chk("refetch_addr", imem_bus.imem_addr, 32'h0040_0000);
    fetch_wait(1, 32'h0040_0000);

    @(negedge clk);
    chk("sb_drained", exp_q.size(), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
